// File: rtl/type_pkg.sv
// Shared types and default sizing for the header-type collection path.
package type_pkg;

    localparam int STATE_TYPE_W            = 45;
    localparam int DEFAULT_NUM_CH          = 8;
    localparam int DEFAULT_TYPE_FIFO_DEPTH = 16;

    typedef logic [STATE_TYPE_W-1:0] state_type_t;

    // Channel-tag width; never narrower than one bit.
    function automatic int chan_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: RAM array with registered read feeding a head register.
module sync_fifo_sa #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic             head_valid_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      occ_reg;

    logic push;
    logic pop;
    logic fetch;

    // occ_reg counts every unpopped word, including the one sitting in head_reg.
    always_comb begin
        pop   = rd_en && head_valid_reg;
        full  = (occ_reg == (AW+1)'(DEPTH));
        push  = wr_en && (!full || pop);
        fetch = (occ_reg > {{AW{1'b0}}, head_valid_reg}) && (!head_valid_reg || pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        if (fetch) begin
            head_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fetch) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            occ_reg <= occ_reg + (AW+1)'(push) - (AW+1)'(pop);
            if (fetch) begin
                head_valid_reg <= 1'b1;
            end else if (pop) begin
                head_valid_reg <= 1'b0;
            end
        end
    end

    assign rd_data = head_reg;
    assign empty   = !head_valid_reg;

endmodule

// File: rtl/type_collector_rr.sv
// Per-channel FIFOs merged onto one valid/ready stream by a work-conserving round-robin arbiter.
module type_collector_rr
    import type_pkg::*;
#(
    parameter int NUM_CH     = DEFAULT_NUM_CH,
    parameter int DATA_W     = STATE_TYPE_W,
    parameter int FIFO_DEPTH = DEFAULT_TYPE_FIFO_DEPTH,
    parameter int CH_W       = chan_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_full,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_chan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        ovf,
    input  logic                     ovf_clr
);

    logic [DATA_W-1:0]   heads [NUM_CH];
    logic [NUM_CH-1:0]   empty;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   pop;
    logic [NUM_CH-1:0]   drop;

    logic [CH_W-1:0]     rr_ptr_reg;
    logic [CH_W-1:0]     rr_ptr_next;
    logic [DATA_W-1:0]   out_data_reg;
    logic [CH_W-1:0]     out_chan_reg;
    logic                out_valid_reg;
    logic [NUM_CH-1:0]   ovf_reg;

    logic                load;
    logic                any_req;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_W-1:0]     rot_idx;
    logic [CH_W:0]       grant_sum;
    logic [CH_W:0]       grant_inc;
    logic [CH_W-1:0]     grant;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            sync_fifo_sa #(
                .WIDTH (DATA_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (in_valid[gi]),
                .wr_data (in_data[gi*DATA_W +: DATA_W]),
                .rd_en   (pop[gi]),
                .rd_data (heads[gi]),
                .empty   (empty[gi]),
                .full    (in_full[gi])
            );

            assign req[gi]  = !empty[gi];
            assign pop[gi]  = load && any_req && (grant == CH_W'(gi));
            // A full FIFO still accepts when it is popped in the same cycle.
            assign drop[gi] = in_valid[gi] && in_full[gi] && !pop[gi];
        end
    endgenerate

    // Rotate requests so rr_ptr sits at bit 0, pick the lowest, then rotate back.
    always_comb begin
        load        = !out_valid_reg || out_ready;
        any_req     = |req;
        req_dbl     = {req, req} >> rr_ptr_reg;
        req_rot     = req_dbl[NUM_CH-1:0];
        rot_idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = CH_W'(i);
            end
        end
        grant_sum = {1'b0, rot_idx} + {1'b0, rr_ptr_reg};
        if (grant_sum >= (CH_W+1)'(NUM_CH)) begin
            grant_sum = grant_sum - (CH_W+1)'(NUM_CH);
        end
        grant     = grant_sum[CH_W-1:0];
        grant_inc = {1'b0, grant} + 1'b1;
        if (grant_inc == (CH_W+1)'(NUM_CH)) begin
            grant_inc = '0;
        end
        rr_ptr_next = rr_ptr_reg;
        if (load && any_req) begin
            rr_ptr_next = grant_inc[CH_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            ovf_reg       <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (load) begin
                out_valid_reg <= any_req;
                if (any_req) begin
                    out_data_reg <= heads[grant];
                    out_chan_reg <= grant;
                end
            end
            // A drop in the same cycle as ovf_clr keeps its bit set.
            ovf_reg <= (ovf_reg & ~{NUM_CH{ovf_clr}}) | drop;
        end
    end

    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;
    assign ovf       = ovf_reg;

endmodule
